// File: rtl/db_ram_pkg.sv
// Shared defaults and state encoding for the deblocking-filter line-RAM arbiter.
package db_ram_pkg;

    localparam int RAM_WORD_W = 20;
    localparam int RAM_ADDR_W = 11;
    localparam logic [RAM_WORD_W-1:0] RAM_CLR_VAL = 20'h0;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/db_ram_1p_20x2048.sv
// Synchronous single-port line RAM with active-low chip, write and output enables.
module db_ram_1p_20x2048
    import db_ram_pkg::*;
#(
    parameter int WORD_W = RAM_WORD_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              cen_n_i,
    input  logic              wen_n_i,
    input  logic              oen_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] q_q;

    // The read register holds its last value when the port is idle or writing.
    always_ff @(posedge clk) begin
        if (!cen_n_i) begin
            if (!wen_n_i) begin
                mem_q[addr_i] <= d_i;
            end else begin
                q_q <= mem_q[addr_i];
            end
        end
    end

    assign q_o = oen_n_i ? '0 : q_q;

endmodule

// File: rtl/db_ram_1p_arb.sv
// Round-robin arbiter between writeback and neighbour-fetch paths for the line RAM,
// with a self-timed zero-fill sweep started by clr_i.
module db_ram_1p_arb
    import db_ram_pkg::*;
#(
    parameter int                WORD_W  = RAM_WORD_W,
    parameter int                ADDR_W  = RAM_ADDR_W,
    parameter logic [WORD_W-1:0] CLR_VAL = RAM_CLR_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_done_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_vld_o,
    output logic [WORD_W-1:0] rd_data_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_wr_q, last_wr_d;
    logic              busy_q, busy_d;
    logic              clr_done_q, clr_done_d;
    logic              rd_vld_q;

    logic              clearing;
    logic              wr_gnt, rd_gnt;
    logic              ram_cen_n, ram_wen_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata, ram_rdata;

    assign clearing = (state_q == CLEAR);

    // On contention the side that did not win last time is granted.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (!clearing) begin
            if (wr_req_i && rd_req_i) begin
                wr_gnt = ~last_wr_q;
                rd_gnt = last_wr_q;
            end else begin
                wr_gnt = wr_req_i;
                rd_gnt = rd_req_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        last_wr_d  = last_wr_q;
        if (wr_gnt) begin
            last_wr_d = 1'b1;
        end else if (rd_gnt) begin
            last_wr_d = 1'b0;
        end
        case (state_q)
            SERVE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == '1) begin
                    state_d    = SERVE;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SERVE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SERVE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b1;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            rd_vld_q   <= rd_gnt;
        end
    end

    // The sweep owns the port outright; otherwise the address follows the grant.
    assign ram_cen_n = ~(wr_gnt | rd_gnt | clearing);
    assign ram_wen_n = ~(wr_gnt | clearing);
    assign ram_addr  = clearing ? cnt_q : (wr_gnt ? wr_addr_i : rd_addr_i);
    assign ram_wdata = clearing ? CLR_VAL : wr_data_i;

    db_ram_1p_20x2048 #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .cen_n_i (ram_cen_n),
        .wen_n_i (ram_wen_n),
        .oen_n_i (1'b0),
        .addr_i  (ram_addr),
        .d_i     (ram_wdata),
        .q_o     (ram_rdata)
    );

    assign wr_gnt_o   = wr_gnt;
    assign rd_gnt_o   = rd_gnt;
    assign rd_vld_o   = rd_vld_q;
    assign rd_data_o  = ram_rdata;
    assign busy_o     = busy_q;
    assign clr_done_o = clr_done_q;

endmodule

// File: tb/tb_db_ram_1p_arb.sv
// Self-checking bench for db_ram_1p_arb: vector table, clear-sweep sequences and
// randomized traffic against a memory-array reference model.
module tb_db_ram_1p_arb;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clrPulse = 1'b0;
    logic        wrReq = 1'b0;
    logic [10:0] wrAddr = '0;
    logic [19:0] wrData = '0;
    logic        rdReq = 1'b0;
    logic [10:0] rdAddr = '0;
    logic        busy, clrDone, wrGnt, rdGnt, rdVld;
    logic [19:0] rdData;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wg;
        logic        rg;
        logic        vld;
        logic [19:0] data;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        bit          wr;
        logic [10:0] wa;
        logic [19:0] wd;
        bit          rd;
        logic [10:0] ra;
        bit          expWg;
        bit          expRg;
        bit          expVld;
        bit          chkData;
        logic [19:0] expData;
    } vec_t;

    // Reference model: plain memory image plus a count of sweep writes done.
    logic [19:0] mMem [DEPTH];
    bit          mKnown [DEPTH];
    bit          mClearing = 0;
    int          mIdx = 0;
    bit          mLastWr = 1;
    bit          mPendRd = 0;
    bit          mPendKnown = 0;
    logic [19:0] mPendData = '0;
    bit          mDone = 0;

    db_ram_1p_arb dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clrPulse),
        .busy_o     (busy),
        .clr_done_o (clrDone),
        .wr_req_i   (wrReq),
        .wr_addr_i  (wrAddr),
        .wr_data_i  (wrData),
        .wr_gnt_o   (wrGnt),
        .rd_req_i   (rdReq),
        .rd_addr_i  (rdAddr),
        .rd_gnt_o   (rdGnt),
        .rd_vld_o   (rdVld),
        .rd_data_o  (rdData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, then advance the model
    // past the next rising edge.
    task automatic applyStimulus(input bit wr, input logic [10:0] wa, input logic [19:0] wd,
                                 input bit rd, input logic [10:0] ra, input bit clr,
                                 output obs_t o);
        bit expWg, expRg;
        @(negedge clk);
        wrReq = wr; wrAddr = wa; wrData = wd;
        rdReq = rd; rdAddr = ra; clrPulse = clr;
        #1;
        o.wg = wrGnt; o.rg = rdGnt; o.vld = rdVld; o.data = rdData;
        o.busy = busy; o.done = clrDone;
        expWg = 0;
        expRg = 0;
        if (!mClearing) begin
            if (wr && rd) begin
                expRg = mLastWr;
                expWg = !mLastWr;
            end else begin
                expWg = wr;
                expRg = rd;
            end
        end
        checkOutput("model_wr_gnt", {31'd0, o.wg}, {31'd0, expWg});
        checkOutput("model_rd_gnt", {31'd0, o.rg}, {31'd0, expRg});
        checkOutput("model_rd_vld", {31'd0, o.vld}, {31'd0, mPendRd});
        checkOutput("model_busy", {31'd0, o.busy}, {31'd0, mClearing});
        checkOutput("model_clr_done", {31'd0, o.done}, {31'd0, mDone});
        if (mPendRd && mPendKnown) checkOutput("model_rd_data", {12'd0, o.data}, {12'd0, mPendData});
        mPendRd = expRg;
        mPendKnown = mKnown[ra];
        mPendData = mMem[ra];
        if (expWg) begin
            mMem[wa] = wd;
            mKnown[wa] = 1;
            mLastWr = 1;
        end else if (expRg) begin
            mLastWr = 0;
        end
        mDone = 0;
        if (mClearing) begin
            mMem[mIdx] = '0;
            mKnown[mIdx] = 1;
            mIdx++;
            if (mIdx == DEPTH) begin
                mClearing = 0;
                mDone = 1;
            end
        end else if (clr) begin
            mClearing = 1;
            mIdx = 0;
        end
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        wrReq = 0; rdReq = 0; clrPulse = 0;
        #1;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_rd_vld"}, {31'd0, rdVld}, 32'd0);
        checkOutput({tag, "_clr_done"}, {31'd0, clrDone}, 32'd0);
        mClearing = 0; mIdx = 0; mLastWr = 1; mPendRd = 0; mDone = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [14];
        obs_t o;
        int busyCnt, doneCnt, wgBusy, wgDone;
        bit wrP, rdP;
        logic [10:0] wa, ra;
        logic [19:0] wd;

        for (int i = 0; i < DEPTH; i++) begin
            mKnown[i] = 0;
            mMem[i] = '0;
        end

        // Write-then-read, reset-time read priority, and six-cycle R,W contention.
        vecs[0]  = '{1, 11'd5,  20'h12345, 1, 11'd3, 0, 1, 0, 0, 20'h0};
        vecs[1]  = '{1, 11'd5,  20'h12345, 0, 11'd0, 1, 0, 1, 0, 20'h0};
        vecs[2]  = '{0, 11'd0,  20'h0,     1, 11'd5, 0, 1, 0, 0, 20'h0};
        vecs[3]  = '{0, 11'd0,  20'h0,     0, 11'd0, 0, 0, 1, 1, 20'h12345};
        vecs[4]  = '{1, 11'd10, 20'h00001, 0, 11'd0, 1, 0, 0, 0, 20'h0};
        vecs[5]  = '{1, 11'd10, 20'hAAAAA, 1, 11'd5, 0, 1, 0, 0, 20'h0};
        vecs[6]  = '{1, 11'd10, 20'hAAAAA, 1, 11'd5, 1, 0, 1, 1, 20'h12345};
        vecs[7]  = '{1, 11'd10, 20'hAAAAA, 1, 11'd5, 0, 1, 0, 0, 20'h0};
        vecs[8]  = '{1, 11'd10, 20'hAAAAA, 1, 11'd5, 1, 0, 1, 1, 20'h12345};
        vecs[9]  = '{1, 11'd10, 20'hAAAAA, 1, 11'd5, 0, 1, 0, 0, 20'h0};
        vecs[10] = '{1, 11'd10, 20'hAAAAA, 1, 11'd5, 1, 0, 1, 1, 20'h12345};
        vecs[11] = '{0, 11'd0,  20'h0,     0, 11'd0, 0, 0, 0, 0, 20'h0};
        vecs[12] = '{0, 11'd0,  20'h0,     1, 11'd10, 0, 1, 0, 0, 20'h0};
        vecs[13] = '{0, 11'd0,  20'h0,     0, 11'd0, 0, 0, 1, 1, 20'hAAAAA};

        #12;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_clr_done", {31'd0, clrDone}, 32'd0);
        checkOutput("reset_rd_vld", {31'd0, rdVld}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra, 0, o);
            checkOutput($sformatf("vec%0d_wr_gnt", i), {31'd0, o.wg}, {31'd0, vecs[i].expWg});
            checkOutput($sformatf("vec%0d_rd_gnt", i), {31'd0, o.rg}, {31'd0, vecs[i].expRg});
            checkOutput($sformatf("vec%0d_rd_vld", i), {31'd0, o.vld}, {31'd0, vecs[i].expVld});
            if (vecs[i].chkData) checkOutput($sformatf("vec%0d_rd_data", i), {12'd0, o.data}, {12'd0, vecs[i].expData});
        end

        // Full clear sweep over previously filled words.
        applyStimulus(1, 11'd0, 20'hFFFFF, 0, 11'd0, 0, o);
        applyStimulus(1, 11'd1024, 20'hFFFFF, 0, 11'd0, 0, o);
        applyStimulus(1, 11'd2047, 20'hFFFFF, 0, 11'd0, 0, o);
        applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 1, o);
        busyCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 2100 && doneCnt == 0; i++) begin
            applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);
            if (o.busy) busyCnt++;
            if (o.done) doneCnt++;
        end
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd0, 0, o);
        checkOutput("sweepA_busy_cycles", busyCnt, 2048);
        checkOutput("sweepA_done_pulses", doneCnt + {31'd0, o.done}, 1);
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd1024, 0, o);
        checkOutput("sweepA_read0", {12'd0, o.data}, 32'd0);
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd2047, 0, o);
        checkOutput("sweepA_read1024", {12'd0, o.data}, 32'd0);
        applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);
        checkOutput("sweepA_read2047", {12'd0, o.data}, 32'd0);

        // Randomized traffic with requests held until granted.
        wrP = 0; rdP = 0; wa = '0; ra = '0; wd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!wrP && $urandom_range(0, 1) == 1) begin
                wrP = 1;
                wa = 11'($urandom_range(0, 15));
                wd = 20'($urandom);
            end
            if (!rdP && $urandom_range(0, 1) == 1) begin
                rdP = 1;
                ra = 11'($urandom_range(0, 15));
            end
            applyStimulus(wrP, wa, wd, rdP, ra, 0, o);
            if (o.wg) wrP = 0;
            if (o.rg) rdP = 0;
        end
        applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);

        // Read granted in the clr_i cycle, write held across the sweep, clr_i re-pulsed mid-sweep.
        applyStimulus(1, 11'd7, 20'h0BEEF, 0, 11'd0, 0, o);
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd7, 1, o);
        checkOutput("clr_cycle_rd_gnt", {31'd0, o.rg}, 32'd1);
        busyCnt = 0; doneCnt = 0; wgBusy = 0; wgDone = 0;
        for (int i = 0; i < 2100 && doneCnt == 0; i++) begin
            applyStimulus(1, 11'd20, 20'h33333, 0, 11'd0, (i == 500), o);
            if (i == 0) begin
                checkOutput("clr_cycle_rd_vld", {31'd0, o.vld}, 32'd1);
                checkOutput("clr_cycle_rd_data", {12'd0, o.data}, 32'h0BEEF);
            end
            if (o.busy) busyCnt++;
            if (o.busy && o.wg) wgBusy++;
            if (o.done) begin
                doneCnt++;
                if (o.wg) wgDone++;
            end
        end
        checkOutput("sweepB_busy_cycles", busyCnt, 2048);
        checkOutput("sweepB_wr_gnt_busy", wgBusy, 0);
        checkOutput("sweepB_wr_gnt_done", wgDone, 1);
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd20, 0, o);
        applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);
        checkOutput("sweepB_held_write", {12'd0, o.data}, 32'h33333);

        // Reset with a read in flight, then reset part-way through a sweep.
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd20, 0, o);
        doReset("rst_mid_read");
        applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 1, o);
        for (int i = 0; i < 100; i++) applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);
        checkOutput("pre_rst_busy", {31'd0, o.busy}, 32'd1);
        doReset("rst_mid_clear");
        applyStimulus(0, 11'd0, 20'h0, 1, 11'd7, 0, o);
        checkOutput("post_rst_lone_rd_gnt", {31'd0, o.rg}, 32'd1);
        applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);
        checkOutput("post_rst_rd_data", {12'd0, o.data}, 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 2100; i++) begin
            applyStimulus(0, 11'd0, 20'h0, 0, 11'd0, 0, o);
            if (o.done || o.busy) doneCnt++;
        end
        checkOutput("post_rst_no_done", doneCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
